// File: rtl/n2_issue_queue_scb_pkg.sv
// Shared types for the decode-side issue queue and its register scoreboard.
package n2_issue_queue_scb_pkg;

  // Encoding 3 is reserved and behaves exactly like CLS_LONG everywhere.
  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LONG  = 2'd1,
    CLS_NODST = 2'd2,
    CLS_RSVD  = 2'd3
  } uop_cls_e;

  typedef struct packed {
    logic       busy;
    logic       alu;
    logic [1:0] age;
  } scb_entry_t;

  function automatic logic [1:0] dec_age(input logic [1:0] age);
    return (age == 2'd0) ? 2'd0 : age - 2'd1;
  endfunction

endpackage

// File: rtl/n2_scoreboard.sv
// Per-register busy/forwarding tracker: hazard and bypass flags for the queue head,
// allocation on issue, write-back release and a flush that squashes only ALU producers.
module n2_scoreboard
  import n2_issue_queue_scb_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int NWB     = 4,
  parameter int FWD_LAT = 1,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RIDX_W-1:0]     rs1,
  input  logic [RIDX_W-1:0]     rs2,
  input  logic [RIDX_W-1:0]     rd,
  input  uop_cls_e              cls,
  input  logic                  alloc,
  input  logic                  flush,
  input  logic [NWB-1:0]        wb_v,
  input  logic [NWB*RIDX_W-1:0] wb_rd,
  output logic                  hazard,
  output logic                  fwd1,
  output logic                  fwd2
);

  scb_entry_t       scb     [NREGS];
  scb_entry_t       scb_nxt [NREGS];
  logic [NREGS-1:0] busy_v;
  logic [NREGS-1:0] fwd_v;
  logic [NREGS-1:0] wb_clr;
  logic             src1_haz;
  logic             src2_haz;
  logic             dst_haz;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy_v[r] = scb[r].busy;
      fwd_v[r]  = scb[r].busy && scb[r].alu && (scb[r].age == 2'd0);
    end
  end

  assign src1_haz = (rs1 != '0) && busy_v[rs1] && !fwd_v[rs1];
  assign src2_haz = (rs2 != '0) && busy_v[rs2] && !fwd_v[rs2];
  assign dst_haz  = (rd != '0) && (cls != CLS_NODST) && busy_v[rd];
  assign hazard   = src1_haz || src2_haz || dst_haz;
  assign fwd1     = (rs1 != '0) && fwd_v[rs1];
  assign fwd2     = (rs2 != '0) && fwd_v[rs2];

  // NOTE: every variable written in always_comb gets a default first; otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    wb_clr = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_v[k]) wb_clr[wb_rd[k*RIDX_W +: RIDX_W]] = 1'b1;
    end
  end

  // Allocation is applied last so an issue beats a same-cycle write-back to its rd.
  always_comb begin
    scb_nxt = scb;
    for (int r = 0; r < NREGS; r++) begin
      scb_nxt[r].age = dec_age(scb[r].age);
      if (wb_clr[r]) scb_nxt[r].busy = 1'b0;
      if (flush && scb[r].busy && scb[r].alu) begin
        scb_nxt[r].busy = 1'b0;
        scb_nxt[r].alu  = 1'b0;
      end
      if (alloc && (cls != CLS_NODST) && (rd == RIDX_W'(r))) begin
        scb_nxt[r].busy = 1'b1;
        scb_nxt[r].alu  = (cls == CLS_ALU);
        scb_nxt[r].age  = (cls == CLS_ALU) ? 2'(FWD_LAT) : 2'd0;
      end
    end
    scb_nxt[0] = '0;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
  // blocking here would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) scb[r] <= '0;
    end else begin
      scb <= scb_nxt;
    end
  end

endmodule

// File: rtl/n2_issue_queue_scb.sv
// Decode issue queue: circular FIFO with empty-queue bypass, single issue per cycle,
// registered issue outputs, occupancy/overflow reporting and perf counters.
module n2_issue_queue_scb
  import n2_issue_queue_scb_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int NWB      = 4,
  parameter int FWD_LAT  = 1,
  parameter int AFULL_TH = DEPTH - 2,
  localparam int RIDX_W  = $clog2(NREGS),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_v_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [RIDX_W-1:0]     wr_rs1_i,
  input  logic [RIDX_W-1:0]     wr_rs2_i,
  input  logic [RIDX_W-1:0]     wr_rd_i,
  input  logic [1:0]            wr_cls_i,
  output logic                  afull_o,
  output logic [CW-1:0]         count_o,
  output logic                  ovf_o,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  iss_v_o,
  output logic [DATA_W-1:0]     iss_data_o,
  output logic [RIDX_W-1:0]     iss_rd_o,
  output logic                  fwd1_o,
  output logic                  fwd2_o,
  input  logic [NWB-1:0]        wb_v_i,
  input  logic [NWB*RIDX_W-1:0] wb_rd_i,
  output logic [31:0]           perf_issue_o,
  output logic [31:0]           perf_stall_o
);

  localparam int AW = CW - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [RIDX_W-1:0] rd;
    uop_cls_e          cls;
  } iq_entry_t;

  iq_entry_t     mem [DEPTH];
  iq_entry_t     in_entry;
  iq_entry_t     head;
  logic [CW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic          empty, full, head_v, hazard, fwd1, fwd2, fire, pop, push;

  assign in_entry = '{data: wr_data_i, rs1: wr_rs1_i, rs2: wr_rs2_i, rd: wr_rd_i,
                      cls: uop_cls_e'(wr_cls_i)};

  // The pointer MSB is a wrap bit: equal pointers mean empty, differing MSBs mean full.
  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign head_v = !empty || wr_v_i;
  assign head   = empty ? in_entry : mem[rd_ptr[AW-1:0]];

  assign fire = head_v && !hazard && !stall_i && !flush_i;
  assign pop  = fire && !empty;
  // A bypassed uop that issues never lands in the array; a full queue accepts only
  // when the head leaves in the same cycle.
  assign push = wr_v_i && !flush_i && !(empty && fire) && (!full || pop);

  assign count_o = wr_ptr - rd_ptr;

  n2_scoreboard #(
    .NREGS   (NREGS),
    .NWB     (NWB),
    .FWD_LAT (FWD_LAT)
  ) u_scb (
    .clk    (clk),
    .rst    (rst),
    .rs1    (head.rs1),
    .rs2    (head.rs2),
    .rd     (head.rd),
    .cls    (head.cls),
    .alloc  (fire),
    .flush  (flush_i),
    .wb_v   (wb_v_i),
    .wb_rd  (wb_rd_i),
    .hazard (hazard),
    .fwd1   (fwd1),
    .fwd2   (fwd2)
  );

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    if (flush_i) begin
      rd_ptr_nxt = wr_ptr;
    end else begin
      if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
      if (push) wr_ptr_nxt = wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      afull_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr_nxt;
      afull_o <= (CW'(wr_ptr_nxt - rd_ptr_nxt) >= CW'(AFULL_TH));
      if (wr_v_i && full && !pop && !flush_i) ovf_o <= 1'b1;
    end
  end

  // NOTE: the entry array has no reset; entries are only read between the pointers,
  // so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_o      <= 1'b0;
      iss_data_o   <= '0;
      iss_rd_o     <= '0;
      fwd1_o       <= 1'b0;
      fwd2_o       <= 1'b0;
      perf_issue_o <= '0;
      perf_stall_o <= '0;
    end else begin
      iss_v_o <= fire;
      if (fire) begin
        iss_data_o   <= head.data;
        iss_rd_o     <= head.rd;
        fwd1_o       <= fwd1;
        fwd2_o       <= fwd2;
        perf_issue_o <= perf_issue_o + 32'd1;
      end
      if (head_v && hazard && !flush_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_n2_issue_queue_scb.sv
// Randomised and directed bench for n2_issue_queue_scb against a queue-based reference model.
module tb_n2_issue_queue_scb;

  localparam int DEPTH    = 8;
  localparam int DATA_W   = 64;
  localparam int NREGS    = 32;
  localparam int NWB      = 4;
  localparam int FWD_LAT  = 1;
  localparam int AFULL_TH = DEPTH - 2;
  localparam int RW       = 5;
  localparam int CW       = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_v;
  logic [DATA_W-1:0] wr_data;
  logic [RW-1:0]     wr_rs1, wr_rs2, wr_rd;
  logic [1:0]        wr_cls;
  logic              afull;
  logic [CW-1:0]     count;
  logic              ovf;
  logic              stall, flush;
  logic              iss_v;
  logic [DATA_W-1:0] iss_data;
  logic [RW-1:0]     iss_rd;
  logic              fwd1, fwd2;
  logic [NWB-1:0]    wb_v;
  logic [RW-1:0]     wb_rd_a [NWB];
  logic [NWB*RW-1:0] wb_rd;
  logic [31:0]       perf_issue, perf_stall;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NWB; k++) wb_rd[k*RW +: RW] = wb_rd_a[k];
  end

  n2_issue_queue_scb #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .NREGS(NREGS), .NWB(NWB),
    .FWD_LAT(FWD_LAT), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst(rst), .wr_v_i(wr_v), .wr_data_i(wr_data), .wr_rs1_i(wr_rs1),
    .wr_rs2_i(wr_rs2), .wr_rd_i(wr_rd), .wr_cls_i(wr_cls), .afull_o(afull),
    .count_o(count), .ovf_o(ovf), .stall_i(stall), .flush_i(flush), .iss_v_o(iss_v),
    .iss_data_o(iss_data), .iss_rd_o(iss_rd), .fwd1_o(fwd1), .fwd2_o(fwd2),
    .wb_v_i(wb_v), .wb_rd_i(wb_rd), .perf_issue_o(perf_issue), .perf_stall_o(perf_stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain queue of uops plus per-register busy/alu/age numbers.
  typedef struct {
    logic [63:0] data;
    int rs1, rs2, rd, cls;
  } uop_t;

  uop_t        q[$];
  int          busy [NREGS];
  int          alu  [NREGS];
  int          age  [NREGS];
  bit          m_ovf, m_iss_v, m_fwd1, m_fwd2;
  logic [63:0] m_iss_data;
  int          m_iss_rd;
  logic [31:0] m_perf_issue, m_perf_stall;

  function automatic bit fwdable(input int r);
    return busy[r] != 0 && alu[r] != 0 && age[r] == 0;
  endfunction

  function automatic bit src_haz(input int r);
    return r != 0 && busy[r] != 0 && !fwdable(r);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < NREGS; r++) begin busy[r] = 0; alu[r] = 0; age[r] = 0; end
    m_ovf = 0; m_iss_v = 0; m_fwd1 = 0; m_fwd2 = 0; m_iss_data = '0; m_iss_rd = 0;
    m_perf_issue = '0; m_perf_stall = '0;
  endtask

  task automatic model_step();
    uop_t in_u, h;
    bit hv, haz, fir, bypassed;
    in_u = '{wr_data, int'(wr_rs1), int'(wr_rs2), int'(wr_rd), int'(wr_cls)};
    h = in_u;
    hv = 0;
    if (q.size() > 0) begin hv = 1; h = q[0]; end
    else if (wr_v) hv = 1;
    haz = hv && (src_haz(h.rs1) || src_haz(h.rs2) ||
                 (h.rd != 0 && h.cls != 2 && busy[h.rd] != 0));
    fir = hv && !haz && !stall && !flush;
    if (hv && haz && !flush) m_perf_stall++;
    m_iss_v = fir;
    if (fir) begin
      m_iss_data = h.data;
      m_iss_rd   = h.rd;
      m_fwd1     = h.rs1 != 0 && fwdable(h.rs1);
      m_fwd2     = h.rs2 != 0 && fwdable(h.rs2);
      m_perf_issue++;
    end
    for (int r = 1; r < NREGS; r++) begin
      int nb, na, ng;
      nb = busy[r]; na = alu[r]; ng = (age[r] > 0) ? age[r] - 1 : 0;
      for (int k = 0; k < NWB; k++) if (wb_v[k] && int'(wb_rd_a[k]) == r) nb = 0;
      if (flush && busy[r] != 0 && alu[r] != 0) begin nb = 0; na = 0; end
      if (fir && h.rd == r && h.cls != 2) begin
        nb = 1; na = (h.cls == 0); ng = (h.cls == 0) ? FWD_LAT : 0;
      end
      busy[r] = nb; alu[r] = na; age[r] = ng;
    end
    if (flush) begin
      q.delete();
    end else begin
      bypassed = (q.size() == 0) && fir;
      if (fir && !bypassed) void'(q.pop_front());
      if (wr_v && !bypassed) begin
        if (q.size() < DEPTH) q.push_back(in_u);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    check("count", 64'(count), 64'(q.size()));
    check("afull", 64'(afull), 64'(q.size() >= AFULL_TH));
    check("ovf", 64'(ovf), 64'(m_ovf));
    check("iss_v", 64'(iss_v), 64'(m_iss_v));
    check("perf_issue", 64'(perf_issue), 64'(m_perf_issue));
    check("perf_stall", 64'(perf_stall), 64'(m_perf_stall));
    if (m_iss_v) begin
      check("iss_data", iss_data, m_iss_data);
      check("iss_rd", 64'(iss_rd), 64'(m_iss_rd));
      check("fwd1", 64'(fwd1), 64'(m_fwd1));
      check("fwd2", 64'(fwd2), 64'(m_fwd2));
    end
  endtask

  task automatic idle();
    wr_v = 0; wr_data = '0; wr_rs1 = '0; wr_rs2 = '0; wr_rd = '0; wr_cls = '0;
    stall = 0; flush = 0; wb_v = '0;
    for (int k = 0; k < NWB; k++) wb_rd_a[k] = '0;
  endtask

  task automatic uop(input int rs1, input int rs2, input int rd, input int cls);
    wr_v = 1; wr_data = {$urandom, $urandom};
    wr_rs1 = RW'(rs1); wr_rs2 = RW'(rs2); wr_rd = RW'(rd); wr_cls = 2'(cls);
  endtask

  task automatic wb1(input int port, input int rd);
    wb_v[port] = 1'b1; wb_rd_a[port] = RW'(rd);
  endtask

  // Inputs are already driven; the model advances across the edge and outputs are
  // compared at the following falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 64'(count), 0);
    check({tag, "_afull"}, 64'(afull), 0);
    check({tag, "_ovf"}, 64'(ovf), 0);
    check({tag, "_iss_v"}, 64'(iss_v), 0);
    check({tag, "_iss_data"}, iss_data, 0);
    check({tag, "_iss_rd"}, 64'(iss_rd), 0);
    check({tag, "_fwd"}, 64'({fwd1, fwd2}), 0);
    check({tag, "_perf"}, {perf_issue, perf_stall}, 0);
  endtask

  logic [31:0] stall_base;

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Bypass into an empty queue: issues next cycle, never occupies an entry.
    uop(0, 0, 5, 0); step();
    check("byp_v", 64'(iss_v), 1);
    check("byp_rd", 64'(iss_rd), 5);
    check("byp_count", 64'(count), 0);
    idle(); wb1(0, 5); step();

    // ALU producer then consumer: one stall cycle, then forwarded.
    idle(); uop(0, 0, 3, 0); step();
    idle(); uop(3, 0, 0, 2); step();
    check("fwd_stall", 64'(iss_v), 0);
    idle(); step();
    check("fwd_issue", 64'(iss_v), 1);
    check("fwd_fwd1", 64'(fwd1), 1);
    idle(); wb1(1, 3); step();

    // LONG producer: consumer waits for write-back on port 2, not forwarded.
    idle(); uop(0, 0, 7, 1); step();
    stall_base = perf_stall;
    idle(); uop(0, 7, 0, 2); step();
    idle(); step(); step();
    idle(); wb1(2, 7); step();
    check("long_wait", 64'(iss_v), 0);
    idle(); step();
    check("long_issue", 64'(iss_v), 1);
    check("long_fwd2", 64'(fwd2), 0);
    check("long_stalls", 64'(perf_stall - stall_base), 4);

    // Fill to full under stall, overflow on the ninth write, then drain in order.
    check("ovf_pre", 64'(ovf), 0);
    for (int i = 0; i < DEPTH; i++) begin idle(); stall = 1; uop(0, 0, 0, 2); step(); end
    check("full_count", 64'(count), DEPTH);
    check("full_afull", 64'(afull), 1);
    idle(); stall = 1; uop(0, 0, 0, 2); step();
    check("full_ovf", 64'(ovf), 1);
    check("full_drop", 64'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin idle(); step(); end
    check("drain_count", 64'(count), 0);

    // Flush: ALU busy is squashed, LONG busy survives, queue empties, no issue.
    idle(); uop(0, 0, 4, 0); step();
    idle(); uop(0, 0, 9, 1); step();
    for (int i = 0; i < 4; i++) begin idle(); stall = 1; uop(0, 0, 0, 2); step(); end
    idle(); flush = 1; uop(0, 0, 0, 2); step();
    check("flush_count", 64'(count), 0);
    check("flush_iss", 64'(iss_v), 0);
    idle(); uop(4, 0, 0, 2); step();
    check("flush_alu_free", 64'(iss_v), 1);
    idle(); uop(9, 0, 0, 2); step();
    check("flush_long_busy", 64'(iss_v), 0);
    idle(); wb1(1, 9); step();
    idle(); step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        uop($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < NWB; k++)
        if ($urandom_range(0, 3) == 0) wb1(k, $urandom_range(0, 7));
      step();
    end

    // Asynchronous reset mid-cycle with queued entries and a busy register.
    idle(); for (int k = 0; k < NWB; k++) wb1(k, k + 1); step();
    idle(); wb1(0, 6); wb1(1, 7); wb1(2, 0); flush = 1; step();
    idle(); uop(0, 0, 2, 0); step();
    for (int i = 0; i < 3; i++) begin idle(); stall = 1; uop(0, 0, 0, 2); step(); end
    idle();
    #2 rst = 1'b1;
    #1 check_reset_values("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    uop(0, 0, 2, 0); step();
    check("post_rst_issue", 64'(iss_v), 1);
    check("post_rst_rd", 64'(iss_rd), 2);
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
